// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for uart_tx_fifo: write port, serial output and status flags.
// The host drives the write strobe and data; the transmitter drives everything else.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_wr;
  logic                 txd;
  logic                 tx_busy;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_ovf;

  modport master (
    output tx_data,
    output tx_wr,
    input  txd,
    input  tx_busy,
    input  tx_full,
    input  tx_empty,
    input  tx_ovf
  );

  modport slave (
    input  tx_data,
    input  tx_wr,
    output txd,
    output tx_busy,
    output tx_full,
    output tx_empty,
    output tx_ovf
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small transmit FIFO and edge-qualified writes.
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits; CLK_DIV clocks per bit.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;

  logic                 wr_prev_q;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 wr_edge;
  logic                 push;
  logic                 pop;
  logic                 baud_done;
  logic [DATA_BITS-1:0] pop_word;

  assign baud_done = (baud_q == '0);
  assign pop_word  = mem_q[rd_ptr_q];

  // Fullness is judged on the registered flag, so a write that meets a full FIFO
  // is dropped even when the transmitter pops on the same edge.
  always_comb begin
    wr_edge  = bus.tx_wr & ~wr_prev_q;
    push     = wr_edge & ~full_q;
    ovf_d    = wr_edge & full_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  // Frame sequencer; the word and its parity are captured at pop so later
  // changes on tx_data cannot disturb a frame in flight.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_done ? BAUD_MAX : baud_q - BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    txd_d   = 1'b1;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          baud_d  = BAUD_MAX;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          if (bit_q == LAST_STOP) begin
            bit_d = '0;
            if (!empty_q) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d = pop_word;
      par_d   = (PARITY == 1) ? ~^pop_word : ^pop_word;
    end

    // txd is registered from the next state so the pin never glitches.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      wr_prev_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      wr_prev_q <= bus.tx_wr;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.tx_data;
    end
  end

  assign bus.txd      = txd_q;
  assign bus.tx_busy  = (state_q != S_IDLE);
  assign bus.tx_full  = full_q;
  assign bus.tx_empty = empty_q;
  assign bus.tx_ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three frame formats driven by shared stimulus, a timeline
// model of FIFO occupancy and a serial-line monitor fed from a per-channel scoreboard.
module tb_uart_tx_fifo;

  localparam int NCH = 3;
  localparam int CDIV  [NCH] = '{4, 4, 3};
  localparam int NB    [NCH] = '{8, 8, 7};
  localparam int PAR   [NCH] = '{0, 2, 1};
  localparam int NSTOP [NCH] = '{1, 1, 2};
  localparam int DEPTH [NCH] = '{4, 4, 2};

  logic       clk;
  logic       reset;
  logic       tx_wr;
  logic [8:0] tx_data;

  logic [NCH-1:0] txd_v, busy_v, full_v, empty_v, ovf_v;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  uart_tx_fifo_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_fifo_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_fifo_if #(.DATA_BITS(7)) bus2 ();

  assign bus0.tx_wr   = tx_wr;
  assign bus1.tx_wr   = tx_wr;
  assign bus2.tx_wr   = tx_wr;
  assign bus0.tx_data = tx_data[7:0];
  assign bus1.tx_data = tx_data[7:0];
  assign bus2.tx_data = tx_data[6:0];

  assign txd_v   = {bus2.txd,      bus1.txd,      bus0.txd};
  assign busy_v  = {bus2.tx_busy,  bus1.tx_busy,  bus0.tx_busy};
  assign full_v  = {bus2.tx_full,  bus1.tx_full,  bus0.tx_full};
  assign empty_v = {bus2.tx_empty, bus1.tx_empty, bus0.tx_empty};
  assign ovf_v   = {bus2.tx_ovf,   bus1.tx_ovf,   bus0.tx_ovf};

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  uart_tx_fifo #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(2))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int frame_len(input int c);
    return CDIV[c] * (1 + NB[c] + ((PAR[c] != 0) ? 1 : 0) + NSTOP[c]);
  endfunction

  // Expected line level for bit slot idx of a frame carrying word w.
  function automatic logic exp_bit(input int c, input logic [8:0] w, input int idx);
    int ones;
    ones = $countones(w);
    if (idx == 0) return 1'b0;
    if (idx <= NB[c]) return w[idx-1];
    if (PAR[c] != 0 && idx == NB[c] + 1) return (PAR[c] == 2) ? ones[0] : ~ones[0];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input int ch, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s ch%0d actual=%0d expected=%0d at %0t", name, ch, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [8:0] data, input int cycles);
    tx_wr   = wr;
    tx_data = data;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model: words enter when the FIFO has room before this edge; a word leaves
  // when one is held and no frame is still running (a frame lasts frame_len cycles).
  logic [8:0] sbq [NCH][$];
  int     m_count    [NCH];
  longint m_last_pop [NCH];
  bit     m_have     [NCH];
  bit     exp_full   [NCH];
  bit     exp_empty  [NCH];
  bit     exp_ovf    [NCH];
  bit     exp_busy   [NCH];
  bit     m_wrprev;
  longint cyc;

  initial begin
    bit wr_edge;
    int cb;
    int len;
    bit pop_now;
    logic [8:0] mask;
    cyc = 0;
    m_wrprev = 0;
    for (int c = 0; c < NCH; c++) begin
      m_count[c] = 0; m_have[c] = 0; exp_full[c] = 0; exp_empty[c] = 1;
      exp_ovf[c] = 0; exp_busy[c] = 0;
    end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_wrprev = 0;
        for (int c = 0; c < NCH; c++) begin
          m_count[c] = 0; m_have[c] = 0; exp_full[c] = 0; exp_empty[c] = 1;
          exp_ovf[c] = 0; exp_busy[c] = 0;
          sbq[c].delete();
        end
      end else begin
        wr_edge = tx_wr && !m_wrprev;
        for (int c = 0; c < NCH; c++) begin
          cb = m_count[c];
          len = frame_len(c);
          pop_now = (cb > 0) && (!m_have[c] || cyc >= m_last_pop[c] + len);
          if (pop_now) begin
            m_have[c] = 1;
            m_last_pop[c] = cyc;
            m_count[c]--;
          end
          exp_ovf[c] = 0;
          if (wr_edge) begin
            if (cb < DEPTH[c]) begin
              mask = 9'((1 << NB[c]) - 1);
              sbq[c].push_back(tx_data & mask);
              m_count[c]++;
            end else begin
              exp_ovf[c] = 1;
            end
          end
          exp_full[c]  = (m_count[c] == DEPTH[c]);
          exp_empty[c] = (m_count[c] == 0);
          exp_busy[c]  = m_have[c] && (cyc < m_last_pop[c] + len);
        end
        m_wrprev = tx_wr;
        cyc++;
      end
    end
  end

  // Status flags against the model every cycle, plus an idle line level check.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int c = 0; c < NCH; c++) begin
        checkOutput("tx_full",  c, full_v[c],  exp_full[c]);
        checkOutput("tx_empty", c, empty_v[c], exp_empty[c]);
        checkOutput("tx_ovf",   c, ovf_v[c],   exp_ovf[c]);
        checkOutput("tx_busy",  c, busy_v[c],  exp_busy[c]);
        if (!exp_busy[c]) checkOutput("idle_txd", c, txd_v[c], 1);
      end
    end
  end

  // Serial monitor: decodes every frame cycle by cycle against the scoreboard head.
  bit [NCH-1:0] rx_active = '0;
  int           rx_cyc  [NCH];
  int           rx_bad  [NCH];
  logic [8:0]   rx_word [NCH];
  int           frames_done [NCH];

  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (!reset) begin
        rx_active[c] = 1'b0;
      end else begin
        if (!rx_active[c] && txd_v[c] == 1'b0) begin
          checkOutput("frame_expected", c, (sbq[c].size() != 0), 1);
          if (sbq[c].size() != 0) rx_word[c] = sbq[c].pop_front();
          else rx_word[c] = '0;
          rx_active[c] = 1'b1;
          rx_cyc[c] = 0;
          rx_bad[c] = 0;
        end
        if (rx_active[c]) begin
          if (txd_v[c] !== exp_bit(c, rx_word[c], rx_cyc[c] / CDIV[c])) rx_bad[c]++;
          rx_cyc[c]++;
          if (rx_cyc[c] == frame_len(c)) begin
            checkOutput("frame_bits", c, rx_bad[c], 0);
            frames_done[c]++;
            rx_active[c] = 1'b0;
          end
        end
      end
    end
  end

  // Running totals used by the directed scenarios as before/after deltas.
  int ovf_total [NCH];
  int busy_total [NCH];
  int busy_rises [NCH];
  bit busy_last [NCH];

  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (ovf_v[c]) ovf_total[c]++;
      if (busy_v[c]) busy_total[c]++;
      if (busy_v[c] && !busy_last[c]) busy_rises[c]++;
      busy_last[c] = busy_v[c];
    end
  end

  task automatic waitIdle(input int limit);
    int n;
    bit idle;
    n = 0;
    idle = 0;
    while (!idle && n < limit) begin
      @(negedge clk);
      #1;
      n++;
      idle = (busy_v == '0) && (empty_v == '1) && (rx_active == '0);
      for (int c = 0; c < NCH; c++) if (sbq[c].size() != 0) idle = 0;
    end
    checkOutput("drain", 0, idle, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ovf0 [NCH];
    int bsy0 [NCH];
    int rise0 [NCH];
    int frm0 [NCH];
    int thr;
    localparam int BURST_OVF [NCH] = '{1, 1, 3};
    localparam int BURST_FRM [NCH] = '{5, 5, 3};

    reset = 1'b0;
    tx_wr = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      checkOutput("rst_txd",   c, txd_v[c],   1);
      checkOutput("rst_busy",  c, busy_v[c],  0);
      checkOutput("rst_full",  c, full_v[c],  0);
      checkOutput("rst_empty", c, empty_v[c], 1);
      checkOutput("rst_ovf",   c, ovf_v[c],   0);
    end
    chk_en = 1;
    reset = 1'b1;
    applyStimulus(0, '0, 3);

    $display("[TB] single frame 0x61");
    for (int c = 0; c < NCH; c++) bsy0[c] = busy_total[c];
    applyStimulus(1, 9'h061, 1);
    applyStimulus(0, 9'h061, 1);
    waitIdle(200);
    for (int c = 0; c < NCH; c++) checkOutput("busy_len", c, busy_total[c] - bsy0[c], frame_len(c));

    $display("[TB] write strobe held 500 cycles");
    for (int c = 0; c < NCH; c++) begin frm0[c] = frames_done[c]; ovf0[c] = ovf_total[c]; end
    applyStimulus(1, 9'h061, 500);
    applyStimulus(0, 9'h061, 1);
    waitIdle(200);
    for (int c = 0; c < NCH; c++) begin
      checkOutput("hold_frames", c, frames_done[c] - frm0[c], 1);
      checkOutput("hold_ovf",    c, ovf_total[c] - ovf0[c], 0);
    end

    $display("[TB] burst of six write edges");
    for (int c = 0; c < NCH; c++) begin
      frm0[c] = frames_done[c]; ovf0[c] = ovf_total[c];
      bsy0[c] = busy_total[c];  rise0[c] = busy_rises[c];
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 9'($urandom), 1);
      applyStimulus(0, 9'($urandom), 1);
    end
    waitIdle(600);
    for (int c = 0; c < NCH; c++) begin
      checkOutput("burst_ovf",    c, ovf_total[c] - ovf0[c], BURST_OVF[c]);
      checkOutput("burst_frames", c, frames_done[c] - frm0[c], BURST_FRM[c]);
      checkOutput("burst_busy",   c, busy_total[c] - bsy0[c], BURST_FRM[c] * frame_len(c));
      checkOutput("burst_gapless", c, busy_rises[c] - rise0[c], 1);
    end

    $display("[TB] randomized traffic");
    for (int blk = 0; blk < 30; blk++) begin
      thr = $urandom_range(1, 8);
      for (int i = 0; i < 100; i++) applyStimulus($urandom_range(0, 15) < thr, 9'($urandom), 1);
    end
    applyStimulus(0, '0, 1);
    waitIdle(1000);

    $display("[TB] reset during a two-word burst");
    applyStimulus(1, 9'($urandom), 1);
    applyStimulus(0, 9'($urandom), 1);
    applyStimulus(1, 9'($urandom), 1);
    applyStimulus(0, 9'($urandom), 20);
    #3 reset = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++) begin
      checkOutput("midrst_txd",   c, txd_v[c],   1);
      checkOutput("midrst_empty", c, empty_v[c], 1);
      checkOutput("midrst_busy",  c, busy_v[c],  0);
      checkOutput("midrst_full",  c, full_v[c],  0);
    end
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < NCH; c++) rise0[c] = busy_rises[c];
    applyStimulus(0, '0, 200);
    for (int c = 0; c < NCH; c++) checkOutput("post_reset_quiet", c, busy_rises[c] - rise0[c], 0);

    $display("[TB] recovery frame after reset");
    for (int c = 0; c < NCH; c++) frm0[c] = frames_done[c];
    applyStimulus(1, 9'h0A5, 1);
    applyStimulus(0, 9'h0A5, 1);
    waitIdle(200);
    for (int c = 0; c < NCH; c++) checkOutput("recovery_frames", c, frames_done[c] - frm0[c], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
